afifo_wr_arb: RTL
=================

AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 Parameter W, default 32: payload data width per beat.
REQ-002 Parameter N, default 4: number of requesters; legal values 2..8.
REQ-003 Parameter LW, default 4: burst-length field width; a burst is len+1 beats.
REQ-004 Parameter IDW, default 3: requester-ID tag width; IDW SHALL be >= clog2(N).
REQ-005 wr_clk  in  1  write-domain clock.
REQ-006 wr_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  N  per-requester beat valid.
REQ-008 req_data  in  N*W  per-requester payload; requester i occupies bits [i*W +: W].
REQ-009 req_len  in  N*LW  per-requester burst length minus one; sampled only at grant.
REQ-010 req_ready  out  N  per-requester beat accept.
REQ-011 fifo_full, fifo_afull  in  1 each  full and almost-full flags from the async FIFO write side.
REQ-012 fifo_wr_en  out  1  FIFO push.
REQ-013 fifo_wr_data  out  IDW+1+W  FIFO word {id, last, data}.
REQ-014 busy  out  1  high while a burst is granted.
REQ-015 cur_id  out  IDW  ID of the granted requester; 0 when idle.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 IDLE->BURST: when any req_valid bit is high and fifo_afull=0, the winner SHALL be chosen round-robin, starting from (last_grant+1) mod N.
REQ-018 On the transition to BURST, the block SHALL register the grant, load beat_cnt=req_len[winner] and set busy=1 on the next edge.
REQ-019 No new grant SHALL be issued while fifo_afull=1.
REQ-020 In BURST, req_ready[g] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0 (combinational).
REQ-021 fifo_wr_en SHALL equal BURST && req_valid[g] && !fifo_full; it SHALL never be high while fifo_full=1.
REQ-022 fifo_wr_data SHALL equal {g, (beat_cnt==0), req_data[g]}, with no pipeline delay.
REQ-023 Each accepted beat SHALL decrement beat_cnt.
REQ-024 The beat accepted with beat_cnt==0 SHALL return the FSM to IDLE and update last_grant=g.
REQ-025 Back-to-back bursts SHALL have exactly one IDLE bubble cycle between them.
REQ-026 A requester deasserting req_valid mid-burst SHALL keep the grant; the FSM SHALL wait with no timeout.
REQ-027 fifo_full asserting mid-burst SHALL stall the burst without losing or duplicating beats.
REQ-028 A lone requester SHALL win every arbitration.
REQ-029 With all N requesters continuously valid, grants SHALL rotate 0,1,...,N-1,0.
REQ-030 beat_cnt SHALL be LW bits wide, so len = 2^LW-1 gives 2^LW beats.

Reset
REQ-031 Asserting wr_reset_n low SHALL immediately, asynchronously, force: state=IDLE, busy=0, cur_id=0, beat_cnt=0, fifo_wr_en=0, req_ready=0, last_grant=N-1.
REQ-032 After reset, requester 0 SHALL have first priority.
REQ-033 Reset mid-burst SHALL abandon the burst; the partial burst already in the FIFO is not closed with a last beat, and the downstream consumer is reset alongside.

Structure
REQ-034 The shared package afifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the word-layout constants (ID, LAST and DATA field offsets).
REQ-035 One sub-module, rr_pick, SHALL be used: a combinational N-way round-robin picker with inputs req[N] and last[IDW], and outputs gnt_id and any.
REQ-036 Total RTL SHALL be roughly 150-250 lines.

Verification
REQ-037 Req0 only, len=3, FIFO never full -> 4 pushes on consecutive cycles; last=1 on the 4th beat only; id=0; busy falls after the 4th beat.
REQ-038 All 4 valid, len=0 -> grant ids 0,1,2,3,0; one push every 2 cycles (bubble).
REQ-039 Req2 len=7, fifo_full high on beats 3-5 for 4 cycles -> fifo_wr_en=0 and req_ready[2]=0 while full; exactly 8 pushes total; data in order.
REQ-040 fifo_afull=1 in IDLE with req1 valid -> no grant until afull drops; grant occurs the cycle after.
REQ-041 Reset asserted during beat 2 of a len=5 burst -> fifo_wr_en drops in the same cycle; after release, req1 and req0 both valid -> id 0 granted first.
REQ-042 Req3 drops valid for 5 cycles mid-burst while req0 is valid -> req0 not granted until req3 completes its burst.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared definitions for the async-FIFO write arbiter: FSM states and the
// layout of the pushed FIFO word {id, last, data}.
package afifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DATA_OFS = 0;

    function automatic int last_ofs(input int w);
        return w;
    endfunction

    function automatic int id_ofs(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/afifo_wr_arb_if.sv
// Requester and FIFO-side signal bundle for afifo_wr_arb. The arbiter uses
// the slave modport; the requesters/FIFO model side uses master.
interface afifo_wr_arb_if #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int LW  = 4,
    parameter int IDW = 3
);
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N*LW-1:0]  req_len;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_afull;
    logic             fifo_wr_en;
    logic [IDW+W:0]   fifo_wr_data;
    logic             busy;
    logic [IDW-1:0]   cur_id;

    modport master (
        output req_valid, req_data, req_len, fifo_full, fifo_afull,
        input  req_ready, fifo_wr_en, fifo_wr_data, busy, cur_id
    );

    modport slave (
        input  req_valid, req_data, req_len, fifo_full, fifo_afull,
        output req_ready, fifo_wr_en, fifo_wr_data, busy, cur_id
    );
endinterface

// File: rtl/afifo_wr_arb_rr_pick.sv
// Combinational N-way round-robin picker: searches from last+1 (mod N)
// upward and returns the first requesting index.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && (j == (int'(last) + k) % N) && req[j]) begin
                    any    = 1'b1;
                    gnt_id = IDW'(j);
                end
            end
        end
    end
endmodule

// File: rtl/afifo_wr_arb.sv
// Burst arbiter in front of an async FIFO write port: grants one requester
// at a time round-robin and forwards its len+1 beats tagged with id/last.
//
// state | meaning
// IDLE  | no grant; arbitrate when any request is valid and FIFO not almost full
// BURST | requester r_gnt owns the FIFO until its beat with r_cnt==0 is pushed
module afifo_wr_arb
    import afifo_arb_pkg::*;
#(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int LW  = 4,
    parameter int IDW = 3
) (
    input  logic           wr_clk,
    input  logic           wr_reset_n,
    afifo_wr_arb_if.slave  bus
);
    localparam int LAST_BIT = last_ofs(W);
    localparam int ID_LSB   = id_ofs(W);

    arb_state_t       r_state, w_state_nxt;
    logic [IDW-1:0]   r_gnt, w_gnt_nxt;
    logic [IDW-1:0]   r_last, w_last_nxt;
    logic [LW-1:0]    r_cnt, w_cnt_nxt;

    logic [IDW-1:0]   w_pick;
    logic             w_any;
    logic [LW-1:0]    w_pick_len;
    logic             w_g_valid;
    logic [W-1:0]     w_g_data;
    logic             w_busy;
    logic             w_accept;
    logic             w_cnt_zero;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (bus.req_valid),
        .last   (r_last),
        .gnt_id (w_pick),
        .any    (w_any)
    );

    // Select the granted requester's beat and the candidate winner's length
    always_comb begin
        w_g_valid  = 1'b0;
        w_g_data   = '0;
        w_pick_len = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt == IDW'(i)) begin
                w_g_valid = bus.req_valid[i];
                w_g_data  = bus.req_data[i*W +: W];
            end
            if (w_pick == IDW'(i)) begin
                w_pick_len = bus.req_len[i*LW +: LW];
            end
        end
    end

    always_comb begin
        w_busy     = (r_state == BURST);
        w_accept   = w_busy && w_g_valid && !bus.fifo_full;
        w_cnt_zero = (r_cnt == '0);

        bus.req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_busy && (r_gnt == IDW'(i))) begin
                bus.req_ready[i] = !bus.fifo_full;
            end
        end

        bus.fifo_wr_en                     = w_accept;
        bus.fifo_wr_data                   = '0;
        bus.fifo_wr_data[ID_LSB +: IDW]    = r_gnt;
        bus.fifo_wr_data[LAST_BIT]         = w_cnt_zero;
        bus.fifo_wr_data[DATA_OFS +: W]    = w_g_data;

        bus.busy   = w_busy;
        bus.cur_id = w_busy ? r_gnt : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_any && !bus.fifo_afull) begin
                    w_state_nxt = BURST;
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = w_pick_len;
                end
            end
            BURST: begin
                // A stalled or invalid beat simply holds; there is no timeout
                if (w_accept) begin
                    if (w_cnt_zero) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_gnt;
                    end else begin
                        w_cnt_nxt = r_cnt - LW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_last  <= IDW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule
